fusion_seq: RTL and testbench
=============================

# fusion_seq

Job sequencer that time-multiplexes one `fusion_unit` for dot-product jobs. It accepts a job descriptor carrying widths, signedness and vector length, and streams operand pairs into the unit. It accumulates each pair by feeding the held partial sum back through `psum_in`, then returns the final partial sum over a valid/ready result port. It sits between the layer controller / operand buffers and a combinational `fusion_unit` instance owned by the parent.

## Interface
- `PSUM_W`, 52: partial-sum width, matching `fusion_unit` `psum_in`/`psum_fwd`.
- `DATA_W`, 8: operand width.
- `LEN_W`, 16: job-length counter width.

- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_valid` / `cfg_ready`  in / out  1 / 1  job descriptor handshake.
- `cfg_in_width`, `cfg_weight_width`  in  4 each  operand bit widths; legal values are 1, 2, 4, 8.
- `cfg_s_in`, `cfg_s_weight`  in  1 each  signedness of the operands.
- `cfg_len`  in  LEN_W  number of operand pairs in the job.
- `op_valid` / `op_ready`  in / out  1 / 1  operand-pair handshake.
- `op_in`, `op_weight`  in  DATA_W each  operand pair.
- `fu_in`, `fu_weight`  out  DATA_W each  drive to `fusion_unit`.
- `fu_in_width`, `fu_weight_width`  out  4 each  drive to `fusion_unit`.
- `fu_s_in`, `fu_s_weight`  out  1 each  drive to `fusion_unit`.
- `fu_psum_in`  out  PSUM_W  accumulator fed to `fusion_unit`.
- `fu_psum_fwd`  in  PSUM_W  `fusion_unit` result, equal to `psum_in` plus the fused product; combinational.
- `res_valid` / `res_ready`  out / in  1 / 1  result handshake.
- `res_psum`  out  PSUM_W  final accumulated sum.
- `res_err`  out  1  job was rejected because of an illegal width.
- `busy`  out  1  high whenever the state is not IDLE.
- `stall_cnt`  out  32  present only under `FUSION_SEQ_PERF_EN`.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - `cfg_ready=1`.
  - On `cfg_valid`, latch cfg into the held registers, clear `acc` to 0, set `remaining=cfg_len`, and clear `err`.
  - Illegal width (in or weight not in {1,2,4,8}): set `err=1` and go to DONE.
  - `cfg_len==0`: go to DONE with `acc=0` and `err=0`.
  - Otherwise go to RUN.
- **RUN**
  - `op_ready=1`.
  - `fu_in=op_in` and `fu_weight=op_weight`, both combinational.
  - `fu_psum_in=acc`; the `fu_*` config outputs are driven from the held registers.
  - On `op_valid`: `acc<=fu_psum_fwd` and `remaining<=remaining-1`. When `remaining==1`, go to DONE.
  - No op accepted: `acc` and `remaining` hold.
- **DONE**
  - `res_valid=1`, `res_psum=acc`, `res_err=err`; all three are stable until accepted.
  - On `res_ready`, go to IDLE.
- Outside RUN: `op_ready=0`, `fu_in=0`, `fu_weight=0`.
- Width rules:
  - `acc` wraps modulo 2^PSUM_W; there is no saturation.
  - Sign and lane semantics belong to `fusion_unit`; the sequencer treats the psum as opaque bits.
- A descriptor is never accepted outside IDLE. `cfg_valid` in RUN or DONE is ignored and the descriptor waits.

## Timing
- Reset values:
  - state IDLE, `acc=0`, `remaining=0`, `err=0`.
  - `cfg_ready=1`, `op_ready=0`, `res_valid=0`, `res_psum=0`, `res_err=0`, `busy=0`, `stall_cnt=0`.
  - All `fu_*` outputs 0.
- cfg accepted at cycle T: RUN with `op_ready=1` at T+1, or DONE with `res_valid=1` at T+1.
- Throughput is one operand pair per cycle.
- Last op accepted at T: `res_valid=1` at T+1 with the final sum.
- Result accepted at T: IDLE and `cfg_ready=1` at T+1. The minimum job-to-job gap is one idle cycle.
- `rst` mid-job: the job is discarded, and all registers return to their reset values on the next edge. No result is emitted.
- `rst` has priority over every handshake in the same cycle.

## Configuration
- Macro: `FUSION_SEQ_PERF_EN`.
- Defined:
  - `stall_cnt` port exists.
  - Counts cycles in RUN with `op_valid=0`, plus cycles in DONE with `res_ready=0`.
  - Cleared on cfg accept; saturates at 32'hFFFFFFFF.
  - Resets to 0.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

## Structure
- Package `fusion_pkg` holds:
  - `fusion_seq_state_t` enum (IDLE, RUN, DONE).
  - `PSUM_W`.
  - Legal-width constants.
  - Function `fusion_width_legal(logic [3:0])`.
- One sub-module, `fusion_seq_perf`: saturating stall counter, instantiated only under `FUSION_SEQ_PERF_EN`.
- `fusion_unit` is instantiated by the parent, not inside this block.

## Test plan
- **Unsigned accumulation.** cfg 8/8 unsigned, len 3; ops (3,5), (10,20), (255,255) back-to-back. Required: `res_valid` one cycle after the third op, `res_psum=65240`, `res_err=0`.
- **Signed accumulation.** cfg 8/8 signed/signed, len 2; ops (-128,127), (-1,-1). Required: `res_psum[31:0]=-16255`.
- **Zero length.** `cfg_len=0`. Required: `res_valid=1` the next cycle, `res_psum=0`, `res_err=0`, and `op_ready` never asserted.
- **Illegal width.** `cfg_in_width=3`. Required: `res_err=1`, `res_psum=0`, no `op_ready`, and IDLE after `res_ready`.
- **Back-pressure.** cfg 4/4, len 4; two idle cycles on `op_valid` mid-stream, then `res_ready` held low 4 cycles.
  - Required: `res_psum` stable throughout.
  - Required: `stall_cnt=6` with `FUSION_SEQ_PERF_EN`.
- **Reset mid-job.** `rst` for one cycle after 2 of 4 ops. Required: IDLE, `cfg_ready=1`, no `res_valid`. Then a new job of len 1 with op (2,3). Required: `res_psum=6`.

Source files
------------

// File: rtl/fusion_pkg.sv
// Shared types and constants for the fusion_seq job sequencer.
package fusion_pkg;

    localparam int unsigned PSUM_W = 52;

    localparam logic [3:0] WIDTH_1 = 4'd1;
    localparam logic [3:0] WIDTH_2 = 4'd2;
    localparam logic [3:0] WIDTH_4 = 4'd4;
    localparam logic [3:0] WIDTH_8 = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fusion_seq_state_t;

    function automatic logic fusion_width_legal(input logic [3:0] w);
        return (w == WIDTH_1) || (w == WIDTH_2) || (w == WIDTH_4) || (w == WIDTH_8);
    endfunction

endpackage

// File: rtl/fusion_seq_perf.sv
// Saturating stall counter with synchronous clear.
module fusion_seq_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic [31:0] cnt
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/fusion_seq.sv
// Dot-product job sequencer driving an external combinational fusion_unit.
// Optional stall counter port enabled by FUSION_SEQ_PERF_EN.
module fusion_seq #(
    parameter int unsigned PSUM_W = fusion_pkg::PSUM_W,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_in_width,
    input  logic [3:0]        cfg_weight_width,
    input  logic              cfg_s_in,
    input  logic              cfg_s_weight,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] op_in,
    input  logic [DATA_W-1:0] op_weight,
    output logic [DATA_W-1:0] fu_in,
    output logic [DATA_W-1:0] fu_weight,
    output logic [3:0]        fu_in_width,
    output logic [3:0]        fu_weight_width,
    output logic              fu_s_in,
    output logic              fu_s_weight,
    output logic [PSUM_W-1:0] fu_psum_in,
    input  logic [PSUM_W-1:0] fu_psum_fwd,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [PSUM_W-1:0] res_psum,
    output logic              res_err,
    output logic              busy
`ifdef FUSION_SEQ_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    import fusion_pkg::*;

    fusion_seq_state_t state_q, state_d;
    logic [PSUM_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              err_q, err_d;
    logic [3:0]        in_width_q, in_width_d;
    logic [3:0]        weight_width_q, weight_width_d;
    logic              s_in_q, s_in_d;
    logic              s_weight_q, s_weight_d;

    // State and held job registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            remaining_q    <= '0;
            err_q          <= 1'b0;
            in_width_q     <= '0;
            weight_width_q <= '0;
            s_in_q         <= 1'b0;
            s_weight_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            remaining_q    <= remaining_d;
            err_q          <= err_d;
            in_width_q     <= in_width_d;
            weight_width_q <= weight_width_d;
            s_in_q         <= s_in_d;
            s_weight_q     <= s_weight_d;
        end
    end

    // Next-state and accumulator update
    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        remaining_d    = remaining_q;
        err_d          = err_q;
        in_width_d     = in_width_q;
        weight_width_d = weight_width_q;
        s_in_d         = s_in_q;
        s_weight_d     = s_weight_q;
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    in_width_d     = cfg_in_width;
                    weight_width_d = cfg_weight_width;
                    s_in_d         = cfg_s_in;
                    s_weight_d     = cfg_s_weight;
                    acc_d          = '0;
                    remaining_d    = cfg_len;
                    err_d          = 1'b0;
                    if (!fusion_width_legal(cfg_in_width) || !fusion_width_legal(cfg_weight_width)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (cfg_len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (op_valid) begin
                    acc_d       = fu_psum_fwd;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake and fusion_unit drive
    always_comb begin
        cfg_ready       = 1'b0;
        op_ready        = 1'b0;
        res_valid       = 1'b0;
        res_psum        = '0;
        res_err         = 1'b0;
        fu_in           = '0;
        fu_weight       = '0;
        busy            = (state_q != IDLE);
        fu_psum_in      = acc_q;
        fu_in_width     = in_width_q;
        fu_weight_width = weight_width_q;
        fu_s_in         = s_in_q;
        fu_s_weight     = s_weight_q;
        case (state_q)
            IDLE: cfg_ready = 1'b1;
            RUN: begin
                op_ready  = 1'b1;
                fu_in     = op_in;
                fu_weight = op_weight;
            end
            DONE: begin
                res_valid = 1'b1;
                res_psum  = acc_q;
                res_err   = err_q;
            end
            default: ;
        endcase
    end

`ifdef FUSION_SEQ_PERF_EN
    logic cfg_accept;
    logic stall_inc;

    assign cfg_accept = (state_q == IDLE) && cfg_valid;
    assign stall_inc  = ((state_q == RUN) && !op_valid) || ((state_q == DONE) && !res_ready);

    fusion_seq_perf u_perf (
        .clk (clk),
        .rst (rst),
        .clr (cfg_accept),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_fusion_seq.sv
// Bench for fusion_seq: job-level reference model with per-cycle compare plus
// directed jobs with hand-computed results.
module tb_fusion_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  cfg_in_width;
    logic [3:0]  cfg_weight_width;
    logic        cfg_s_in;
    logic        cfg_s_weight;
    logic [15:0] cfg_len;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op_in;
    logic [7:0]  op_weight;
    logic [7:0]  fu_in;
    logic [7:0]  fu_weight;
    logic [3:0]  fu_in_width;
    logic [3:0]  fu_weight_width;
    logic        fu_s_in;
    logic        fu_s_weight;
    logic [51:0] fu_psum_in;
    logic [51:0] fu_psum_fwd;
    logic        res_valid;
    logic        res_ready;
    logic [51:0] res_psum;
    logic        res_err;
    logic        busy;
`ifdef FUSION_SEQ_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fusion_seq dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_in_width     (cfg_in_width),
        .cfg_weight_width (cfg_weight_width),
        .cfg_s_in         (cfg_s_in),
        .cfg_s_weight     (cfg_s_weight),
        .cfg_len          (cfg_len),
        .op_valid         (op_valid),
        .op_ready         (op_ready),
        .op_in            (op_in),
        .op_weight        (op_weight),
        .fu_in            (fu_in),
        .fu_weight        (fu_weight),
        .fu_in_width      (fu_in_width),
        .fu_weight_width  (fu_weight_width),
        .fu_s_in          (fu_s_in),
        .fu_s_weight      (fu_s_weight),
        .fu_psum_in       (fu_psum_in),
        .fu_psum_fwd      (fu_psum_fwd),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_psum         (res_psum),
        .res_err          (res_err),
        .busy             (busy)
`ifdef FUSION_SEQ_PERF_EN
        ,
        .stall_cnt        (stall_cnt)
`endif
    );

    // Integer value of the low w bits of x, two's complement when s is set.
    function automatic longint opval(input logic [7:0] x, input logic [3:0] w, input logic s);
        longint v;
        int n;
        v = 0;
        n = (int'(w) > 8) ? 8 : int'(w);
        for (int i = 0; i < n; i++) begin
            if (x[i]) v = v + (longint'(1) << i);
        end
        if (s && n > 0 && x[n-1]) v = v - (longint'(1) << n);
        return v;
    endfunction

    function automatic logic [51:0] prod(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] wa, input logic [3:0] wb,
                                         input logic sa, input logic sb);
        return 52'(opval(a, wa, sa) * opval(b, wb, sb));
    endfunction

    // Stand-in for the parent's fusion_unit
    assign fu_psum_fwd = fu_psum_in + prod(fu_in, fu_weight, fu_in_width, fu_weight_width,
                                           fu_s_in, fu_s_weight);

    function automatic logic legal(input logic [3:0] w);
        return (w == 4'd1) || (w == 4'd2) || (w == 4'd4) || (w == 4'd8);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Job-level model: phase 0 waiting for job, 1 collecting pairs, 2 holding result
    int          m_phase;
    logic        m_on;
    logic [51:0] m_acc;
    int          m_left;
    logic        m_err;
    logic [3:0]  m_iw, m_ww;
    logic        m_si, m_sw;
    longint      m_stall;

    initial m_on = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_on    <= 1'b1;
            m_phase <= 0;
            m_acc   <= '0;
            m_left  <= 0;
            m_err   <= 1'b0;
            m_iw    <= '0;
            m_ww    <= '0;
            m_si    <= 1'b0;
            m_sw    <= 1'b0;
            m_stall <= 0;
        end else if (m_on) begin
            if (m_phase == 0) begin
                if (cfg_valid) begin
                    m_iw    <= cfg_in_width;
                    m_ww    <= cfg_weight_width;
                    m_si    <= cfg_s_in;
                    m_sw    <= cfg_s_weight;
                    m_acc   <= '0;
                    m_stall <= 0;
                    m_left  <= int'(cfg_len);
                    m_err   <= !(legal(cfg_in_width) && legal(cfg_weight_width));
                    m_phase <= (!(legal(cfg_in_width) && legal(cfg_weight_width)) || cfg_len == 16'd0) ? 2 : 1;
                end
            end else if (m_phase == 1) begin
                if (op_valid) begin
                    m_acc  <= m_acc + prod(op_in, op_weight, m_iw, m_ww, m_si, m_sw);
                    m_left <= m_left - 1;
                    if (m_left == 1) m_phase <= 2;
                end else begin
                    m_stall <= (m_stall == 64'hFFFF_FFFF) ? m_stall : m_stall + 1;
                end
            end else begin
                if (res_ready) m_phase <= 0;
                else m_stall <= (m_stall == 64'hFFFF_FFFF) ? m_stall : m_stall + 1;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (m_on && !rst) begin
            chk("cfg_ready", 64'(cfg_ready), 64'(m_phase == 0));
            chk("op_ready", 64'(op_ready), 64'(m_phase == 1));
            chk("res_valid", 64'(res_valid), 64'(m_phase == 2));
            chk("busy", 64'(busy), 64'(m_phase != 0));
            chk("res_psum", 64'(res_psum), (m_phase == 2) ? 64'(m_acc) : 64'd0);
            chk("res_err", 64'(res_err), (m_phase == 2) ? 64'(m_err) : 64'd0);
            chk("fu_in", 64'(fu_in), (m_phase == 1) ? 64'(op_in) : 64'd0);
            chk("fu_weight", 64'(fu_weight), (m_phase == 1) ? 64'(op_weight) : 64'd0);
            if (m_phase == 1) begin
                chk("fu_psum_in", 64'(fu_psum_in), 64'(m_acc));
                chk("fu_cfg", 64'({fu_in_width, fu_weight_width, fu_s_in, fu_s_weight}),
                    64'({m_iw, m_ww, m_si, m_sw}));
            end
`ifdef FUSION_SEQ_PERF_EN
            chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input logic [3:0] iw, input logic [3:0] ww, input logic si,
                            input logic sw, input logic [15:0] len);
        cfg_in_width     = iw;
        cfg_weight_width = ww;
        cfg_s_in         = si;
        cfg_s_weight     = sw;
        cfg_len          = len;
        cfg_valid        = 1'b1;
        tick();
        cfg_valid        = 1'b0;
    endtask

    task automatic send_op(input logic [7:0] a, input logic [7:0] b);
        op_in     = a;
        op_weight = b;
        op_valid  = 1'b1;
        tick();
        op_valid  = 1'b0;
        op_in     = '0;
        op_weight = '0;
    endtask

    // Accept the pending result within a bounded number of cycles
    task automatic take_res(input string name, input logic [51:0] psum, input logic err);
        bit got;
        got = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            if (res_valid) begin
                chk({name, "_psum"}, 64'(res_psum), 64'(psum));
                chk({name, "_err"}, 64'(res_err), 64'(err));
                got = 1'b1;
            end
            tick();
        end
        res_ready = 1'b0;
        if (!got) chk({name, "_timeout"}, 64'd0, 64'd1);
        chk({name, "_idle"}, 64'({cfg_ready, busy}), 64'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cfg_valid = 1'b0; cfg_in_width = '0; cfg_weight_width = '0;
        cfg_s_in = 1'b0; cfg_s_weight = 1'b0; cfg_len = '0;
        op_valid = 1'b0; op_in = '0; op_weight = '0; res_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_state", 64'({cfg_ready, op_ready, res_valid, busy, res_err}), 64'b10000);
        chk("rst_psum", 64'(res_psum), 64'd0);
        chk("rst_fu", 64'({fu_in, fu_weight, fu_in_width, fu_weight_width}), 64'd0);
        chk("rst_fu_psum", 64'(fu_psum_in), 64'd0);
        tick();

        // Unsigned 8x8: 15 + 200 + 65025
        send_cfg(4'd8, 4'd8, 1'b0, 1'b0, 16'd3);
        chk("u_op_ready", 64'(op_ready), 64'd1);
        send_op(8'd3, 8'd5);
        send_op(8'd10, 8'd20);
        send_op(8'd255, 8'd255);
        chk("u_res_latency", 64'(res_valid), 64'd1);
        take_res("unsigned", 52'd65240, 1'b0);

        // Signed: -128*127 + (-1)*(-1) = -16255
        send_cfg(4'd8, 4'd8, 1'b1, 1'b1, 16'd2);
        send_op(8'h80, 8'h7F);
        send_op(8'hFF, 8'hFF);
        chk("s_psum_lo", 64'(res_psum[31:0]), 64'h0000_0000_FFFF_C081);
        take_res("signed", 52'hF_FFFF_FFFF_C081, 1'b0);

        // Zero length
        send_cfg(4'd8, 4'd8, 1'b0, 1'b0, 16'd0);
        chk("z_res_valid", 64'({res_valid, op_ready}), 64'b10);
        take_res("zero_len", 52'd0, 1'b0);

        // Illegal width
        send_cfg(4'd3, 4'd8, 1'b0, 1'b0, 16'd5);
        chk("ill_res_valid", 64'({res_valid, op_ready}), 64'b10);
        take_res("illegal", 52'd0, 1'b1);

        // Back-pressure, 4-bit unsigned: 12 + 30 + 56 + 225 = 323
        send_cfg(4'd4, 4'd4, 1'b0, 1'b0, 16'd4);
        send_op(8'd3, 8'd4);
        send_op(8'd5, 8'd6);
        tick();
        tick();
        send_op(8'd7, 8'd8);
        send_op(8'd15, 8'd15);
        for (int i = 0; i < 4; i++) begin
            chk("bp_hold", 64'({res_valid, res_psum}), {11'd0, 1'b1, 52'd323});
            tick();
        end
        take_res("backpressure", 52'd323, 1'b0);
`ifdef FUSION_SEQ_PERF_EN
        chk("bp_stall_cnt", 64'(stall_cnt), 64'd6);
`endif

        // Reset mid-job, then a fresh job
        send_cfg(4'd8, 4'd8, 1'b0, 1'b0, 16'd4);
        send_op(8'd9, 8'd9);
        send_op(8'd7, 8'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_state", 64'({cfg_ready, res_valid, busy, op_ready}), 64'b1000);
        chk("rst_mid_fu_psum", 64'(fu_psum_in), 64'd0);
        tick();
        chk("rst_mid_no_res", 64'(res_valid), 64'd0);
        send_cfg(4'd8, 4'd8, 1'b0, 1'b0, 16'd1);
        send_op(8'd2, 8'd3);
        take_res("after_rst", 52'd6, 1'b0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
